psx_ddr_mem_responder: RTL and testbench

//  Avalon-MM burst slave that answers the PSX GPU DDR bridge's 64-bit master port.

---
 rtl/psx_ddr_pkg.sv | 25 ++
 rtl/psx_ddr_be_ram.sv | 36 +++
 rtl/psx_ddr_mem_responder.sv | 140 ++++++++++++++
 tb/tb_psx_ddr_mem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_ddr_pkg.sv
// Shared types and constants for the PSX GPU DDR responder path.
package psx_ddr_pkg;

    localparam int BURST_W = 3;
    localparam int DATA_W  = 64;
    localparam int BE_W    = 8;
    localparam int LAT_W   = 4;

    // Bridge command sizes as seen on the GPU side of the DDR bridge.
    localparam logic [1:0] CMD_4BYTE  = 2'd0;
    localparam logic [1:0] CMD_8BYTE  = 2'd1;
    localparam logic [1:0] CMD_32BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST
    } resp_state_t;

    function automatic logic [BURST_W-1:0] eff_len(input logic [BURST_W-1:0] len);
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/psx_ddr_be_ram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
module psx_ddr_be_ram
    import psx_ddr_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register doubles as the bus data output, so it holds between beats.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     rdata_q <= '0;
        else if (i_re) rdata_q <= mem_q[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/psx_ddr_mem_responder.sv
// Avalon-MM burst slave standing in for DDR behind the PSX GPU bridge.
// Optional waitrequest injection via `PSX_DDR_STALL_INJECT_EN.
module psx_ddr_mem_responder
    import psx_ddr_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int READ_LATENCY = 2,
    parameter int STALL_PERIOD = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [ADDR_W-1:0]  i_targetAddr,
    input  logic [BURST_W-1:0] i_burstLength,
    input  logic               i_readEnableMem,
    input  logic               i_writeEnableMem,
    input  logic [DATA_W-1:0]  i_dataMem,
    input  logic [BE_W-1:0]    i_byteEnableMem,
    output logic               o_busyMem,
    output logic               o_dataValidMem,
    output logic [DATA_W-1:0]  o_dataMem,
    output logic               o_protoErr
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    resp_state_t        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               stall;
    logic               busy;
    logic               ram_we, ram_re;
    logic [ADDR_W-1:0]  ram_addr;
    logic [BURST_W-1:0] len;

`ifdef PSX_DDR_STALL_INJECT_EN
    logic [7:0] stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                   stall_cnt_q <= '0;
        else if (stall_cnt_q == 8'(STALL_PERIOD-1)) stall_cnt_q <= '0;
        else                                         stall_cnt_q <= stall_cnt_q + 8'd1;
    end

    assign stall = (stall_cnt_q == 8'(STALL_PERIOD-1));
`else
    assign stall = 1'b0;
`endif

    assign busy = i_rst | stall | (state_q == RD_WAIT) | (state_q == RD_BURST);
    assign len  = eff_len(i_burstLength);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        lat_d    = lat_q;
        err_d    = err_q;
        vld_d    = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        case (state_q)
            IDLE: begin
                if (!busy && i_writeEnableMem) begin
                    ram_we   = 1'b1;
                    ram_addr = i_targetAddr;
                    addr_d   = i_targetAddr + ADDR_ONE;
                    rem_d    = len - BURST_W'(1);
                    if (len != BURST_W'(1)) state_d = WR_BURST;
                    if (i_readEnableMem)    err_d   = 1'b1;
                end else if (!busy && i_readEnableMem) begin
                    addr_d  = i_targetAddr;
                    rem_d   = len;
                    lat_d   = LAT_W'(READ_LATENCY-1);
                    state_d = (READ_LATENCY <= 1) ? RD_BURST : RD_WAIT;
                end
            end
            // The RAM read register is the output, so the last wait cycle
            // hands over to RD_BURST one edge before the first beat shows.
            RD_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q <= LAT_W'(1)) state_d = RD_BURST;
            end
            RD_BURST: begin
                ram_re = 1'b1;
                vld_d  = 1'b1;
                addr_d = addr_q + ADDR_ONE;
                rem_d  = rem_q - BURST_W'(1);
                if (rem_q <= BURST_W'(1)) state_d = IDLE;
            end
            WR_BURST: begin
                if (i_readEnableMem) err_d = 1'b1;
                if (!busy && i_writeEnableMem) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + ADDR_ONE;
                    rem_d  = rem_q - BURST_W'(1);
                    if (rem_q <= BURST_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    psx_ddr_be_ram #(.ADDR_W(ADDR_W)) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_addr  (ram_addr),
        .i_we    (ram_we),
        .i_be    (i_byteEnableMem),
        .i_wdata (i_dataMem),
        .i_re    (ram_re),
        .o_rdata (o_dataMem)
    );

    assign o_busyMem      = busy;
    assign o_dataValidMem = vld_q;
    assign o_protoErr     = err_q;

endmodule

// File: tb/tb_psx_ddr_mem_responder.sv
// Directed bench for psx_ddr_mem_responder with a read-beat scoreboard.
module tb_psx_ddr_mem_responder;

    localparam int AW  = 17;
    localparam int LAT = 2;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-1:0] i_targetAddr = '0;
    logic [2:0]    i_burstLength = 3'd1;
    logic          i_readEnableMem = 1'b0;
    logic          i_writeEnableMem = 1'b0;
    logic [63:0]   i_dataMem = '0;
    logic [7:0]    i_byteEnableMem = '0;
    logic          o_busyMem, o_dataValidMem, o_protoErr;
    logic [63:0]   o_dataMem;

    psx_ddr_mem_responder #(.ADDR_W(AW), .READ_LATENCY(LAT), .STALL_PERIOD(5)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_targetAddr     (i_targetAddr),
        .i_burstLength    (i_burstLength),
        .i_readEnableMem  (i_readEnableMem),
        .i_writeEnableMem (i_writeEnableMem),
        .i_dataMem        (i_dataMem),
        .i_byteEnableMem  (i_byteEnableMem),
        .o_busyMem        (o_busyMem),
        .o_dataValidMem   (o_dataValidMem),
        .o_dataMem        (o_dataMem),
        .o_protoErr       (o_protoErr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model [int];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every read beat is matched against the oldest expected beat, data and cycle.
    always @(negedge i_clk) begin
        if (o_dataValidMem === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(o_dataValidMem), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", o_dataMem, e.data);
                chk("rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic void model_wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] w;
        w = model.exists(int'(a)) ? model[int'(a)] : 64'd0;
        for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        model[int'(a)] = w;
    endfunction

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_busyMem === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(o_busyMem), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input logic [2:0] len, input logic [63:0] base,
                            input logic [7:0] be);
        int n;
        n = (len == 3'd0) ? 1 : int'(len);
        i_burstLength    = len;
        i_byteEnableMem  = be;
        i_writeEnableMem = 1'b1;
        for (int k = 0; k < n; k++) begin
            i_targetAddr = (k == 0) ? a : (a ^ 17'h0155);
            i_dataMem    = base + 64'(k);
            wait_accept();
            model_wr(AW'(a + AW'(k)), base + 64'(k), be);
        end
        i_writeEnableMem = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [2:0] len, output int acc);
        int n;
        n = (len == 3'd0) ? 1 : int'(len);
        i_targetAddr    = a;
        i_burstLength   = len;
        i_readEnableMem = 1'b1;
        wait_accept();
        i_readEnableMem = 1'b0;
        acc = cyc;
        for (int k = 0; k < n; k++) exp_q.push_back('{model[int'(AW'(a + AW'(k)))], acc + LAT + k});
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic [63:0] expv);
        i_targetAddr    = a;
        i_burstLength   = 3'd1;
        i_readEnableMem = 1'b1;
        wait_accept();
        i_readEnableMem = 1'b0;
        exp_q.push_back('{expv, cyc + LAT});
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge i_clk);
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int a0, a1;

        // Reset state
        #2;
        chk("rst_busy", 64'(o_busyMem), 64'd1);
        chk("rst_valid", 64'(o_dataValidMem), 64'd0);
        chk("rst_data", o_dataMem, 64'd0);
        chk("rst_err", 64'(o_protoErr), 64'd0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("idle_busy", 64'(o_busyMem), 64'd0);
        @(posedge i_clk);
        #1;

        // 1: single write, single read at latency 2
        wr_burst(17'h00010, 3'd1, 64'h1122334455667788, 8'hFF);
        rd1(17'h00010, 64'h1122334455667788);
        drain();

        // 2: 4-beat write then 4-beat read, busy held, back-to-back accept
        wr_burst(17'h00100, 3'd4, 64'hA0, 8'hFF);
        rd(17'h00100, 3'd4, a0);
        repeat (5) begin
            @(negedge i_clk);
            chk("busy_rd", 64'(o_busyMem), 64'd1);
        end
        @(posedge i_clk);
        #1;
        i_targetAddr    = 17'h00010;
        i_burstLength   = 3'd1;
        i_readEnableMem = 1'b1;
        @(negedge i_clk);
        chk("accept_after_last", 64'(o_busyMem), 64'd0);
        @(posedge i_clk);
        #1;
        i_readEnableMem = 1'b0;
        a1 = cyc;
        chk("accept_cycle", 64'(a1), 64'(a0 + 6));
        exp_q.push_back('{64'h1122334455667788, a1 + LAT});
        drain();

        // 3: byte enables, including an all-zero mask
        wr_burst(17'h00020, 3'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr_burst(17'h00020, 3'd1, 64'h0, 8'h0F);
        rd1(17'h00020, 64'hFFFFFFFF00000000);
        drain();
        wr_burst(17'h00020, 3'd1, 64'h0123456789ABCDEF, 8'h00);
        rd1(17'h00020, 64'hFFFFFFFF00000000);
        drain();

        // 4: address wrap, length 0 treated as 1
        wr_burst(17'h1FFFE, 3'd4, 64'hC0, 8'hFF);
        rd(17'h1FFFE, 3'd4, a0);
        drain();
        rd1(17'h00001, 64'hC3);
        drain();
        wr_burst(17'h00030, 3'd0, 64'h5A5A, 8'hFF);
        rd(17'h00030, 3'd0, a0);
        drain();

        // 5: simultaneous read and write in IDLE
        chk("err_before", 64'(o_protoErr), 64'd0);
        i_targetAddr     = 17'h00040;
        i_burstLength    = 3'd1;
        i_dataMem        = 64'hDEADBEEF0BADF00D;
        i_byteEnableMem  = 8'hFF;
        i_writeEnableMem = 1'b1;
        i_readEnableMem  = 1'b1;
        wait_accept();
        i_writeEnableMem = 1'b0;
        i_readEnableMem  = 1'b0;
        model_wr(17'h00040, 64'hDEADBEEF0BADF00D, 8'hFF);
        @(negedge i_clk);
        chk("err_set", 64'(o_protoErr), 64'd1);
        repeat (6) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        rd1(17'h00040, 64'hDEADBEEF0BADF00D);
        drain();
        chk("err_sticky", 64'(o_protoErr), 64'd1);

        // 6: reset during beat 2 of a read burst
        rd(17'h00100, 3'd4, a0);
        repeat (4) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(o_dataValidMem), 64'd0);
        chk("midrst_data", o_dataMem, 64'd0);
        chk("midrst_busy", 64'(o_busyMem), 64'd1);
        exp_q.delete();
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_idle", 64'(o_busyMem), 64'd0);
        chk("post_rst_err", 64'(o_protoErr), 64'd0);
        @(posedge i_clk);
        #1;
        rd1(17'h00010, 64'h1122334455667788);
        drain();

        // Read during a write burst flags an error and is ignored
        i_targetAddr     = 17'h00050;
        i_burstLength    = 3'd2;
        i_byteEnableMem  = 8'hFF;
        i_dataMem        = 64'h5000;
        i_writeEnableMem = 1'b1;
        wait_accept();
        i_dataMem       = 64'h5001;
        i_readEnableMem = 1'b1;
        wait_accept();
        i_writeEnableMem = 1'b0;
        i_readEnableMem  = 1'b0;
        model_wr(17'h00050, 64'h5000, 8'hFF);
        model_wr(17'h00051, 64'h5001, 8'hFF);
        @(negedge i_clk);
        chk("err_wr_burst", 64'(o_protoErr), 64'd1);
        @(posedge i_clk);
        #1;
        rd(17'h00050, 3'd2, a0);
        drain();

`ifdef PSX_DDR_STALL_INJECT_EN
        wr_burst(17'h00200, 3'd4, 64'hE0, 8'hFF);
        rd(17'h00200, 3'd4, a0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 64'd1, 64'(checks > 100000));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "FAIL global_timeout");
    end

endmodule
